// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the CPU/debug RAM port arbiter.
// Covers the halt-handshake state encodings, the requester IDs and the default widths.
package mem_port_arbiter_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_SHARED = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } arb_state_t;

    // The numeric value doubles as the bit index in the two-bit request/grant vectors.
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin picker that produces a one-hot grant among eligible requesters.
// On a tie, the requester that did not win last time is granted.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic [1:0] i_elig,
    input  req_id_t    i_last,
    output logic [1:0] o_gnt
);

    logic [1:0] w_live;

    always_comb begin
        w_live = i_req & i_elig;
        o_gnt  = w_live;
        if (w_live == 2'b11) begin
            o_gnt = (i_last == REQ_DBG) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port RAM between the CPU and the debug loader, one access per cycle.
// Also implements the halt handshake, which drains CPU reads before debug gets exclusive access.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_halt,
    output logic              dbg_halted,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t r_state, w_state_nxt;
    req_id_t    r_last, w_last_nxt;
    logic       r_pend_valid;
    req_id_t    r_pend_owner;
    logic [1:0] w_elig, w_arb_gnt, w_gnt;
    logic       w_win_we;

    assign w_elig = {1'b1, (r_state == ST_SHARED)};

    rr_arb2 u_rr_arb2 (
        .i_req  ({dbg_req, cpu_req}),
        .i_elig (w_elig),
        .i_last (r_last),
        .o_gnt  (w_arb_gnt)
    );

    assign w_gnt   = reset ? 2'b00 : w_arb_gnt;
    assign cpu_gnt = w_gnt[REQ_CPU];
    assign dbg_gnt = w_gnt[REQ_DBG];

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        w_win_we  = 1'b0;
        if (w_gnt[REQ_CPU]) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            w_win_we  = cpu_we;
        end else if (w_gnt[REQ_DBG]) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            w_win_we  = dbg_we;
        end
    end

    assign mem_we = w_win_we;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            ST_SHARED: if (dbg_halt) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  w_state_nxt = dbg_halt ? ST_HALTED : ST_SHARED;
            ST_HALTED: if (!dbg_halt) w_state_nxt = ST_SHARED;
            default:   w_state_nxt = ST_SHARED;
        endcase
        if (w_gnt[REQ_CPU]) begin
            w_last_nxt = REQ_CPU;
        end else if (w_gnt[REQ_DBG]) begin
            w_last_nxt = REQ_DBG;
        end
        // A held-off CPU must win the first tie after the halt is released.
        if (r_state != ST_SHARED && !dbg_halt) begin
            w_last_nxt = REQ_DBG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_SHARED;
            r_last       <= REQ_DBG;
            r_pend_valid <= 1'b0;
            r_pend_owner <= REQ_CPU;
        end else begin
            r_state      <= w_state_nxt;
            r_last       <= w_last_nxt;
            r_pend_valid <= (w_gnt != 2'b00) && !w_win_we;
            r_pend_owner <= w_gnt[REQ_DBG] ? REQ_DBG : REQ_CPU;
        end
    end

    assign cpu_rvalid = !reset && r_pend_valid && (r_pend_owner == REQ_CPU);
    assign dbg_rvalid = !reset && r_pend_valid && (r_pend_owner == REQ_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    assign dbg_halted = !reset && (r_state == ST_HALTED);

endmodule
